// File: rtl/riscv_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_id_stage
//  Description : RV32I decode/issue stage. Accepts one instruction per cycle
//                from fetch (valid/ready), reads the register file through
//                combinational address/data ports, and presents the ALU
//                function, operands, writeback and branch side-band from a
//                single registered output slot. An optional busy-bit
//                scoreboard interlocks read-after-write hazards. A flush from
//                execute kills the slot and blocks acceptance for that cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro:
//    RISCV_ID_SCOREBOARD_EN  defined   -> busy-bit scoreboard and stall logic
//                            undefined -> no interlock, wb_valid/wb_rd ignored
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rst                 clock (rising edge), async active-high reset
//    if_valid / if_ready      fetch handshake
//    if_inst, if_pc           instruction word and its PC
//    rs1_addr, rs2_addr       register-file read addresses (combinational)
//    rs1_data, rs2_data       register-file read data (combinational)
//    ex_valid / ex_ready      execute handshake for the output slot
//    exec_fun, data1, data2   ALU operation and operands
//    ex_rd, ex_wb_en          destination register and writeback enable
//    ex_is_branch,
//    ex_br_on_eq, ex_br_target  conditional branch side-band
//    ex_illegal               unsupported encoding
//    flush                    kill slot / block acceptance this cycle
//    wb_valid, wb_rd          writeback completion clearing a busy bit
// ============================================================================
module riscv_id_stage #(
    parameter int WORD_LENGTH = 32,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [31:0]            if_inst,
    input  logic [WORD_LENGTH-1:0] if_pc,
    output logic [REG_ADDR_W-1:0]  rs1_addr,
    output logic [REG_ADDR_W-1:0]  rs2_addr,
    input  logic [WORD_LENGTH-1:0] rs1_data,
    input  logic [WORD_LENGTH-1:0] rs2_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [1:0]             exec_fun,
    output logic [WORD_LENGTH-1:0] data1,
    output logic [WORD_LENGTH-1:0] data2,
    output logic [REG_ADDR_W-1:0]  ex_rd,
    output logic                   ex_wb_en,
    output logic                   ex_is_branch,
    output logic                   ex_br_on_eq,
    output logic [WORD_LENGTH-1:0] ex_br_target,
    output logic                   ex_illegal,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_rd
);

    // ALU function encoding presented on exec_fun
    localparam logic [1:0] c_ALU_ADD = 2'd0;
    localparam logic [1:0] c_ALU_SUB = 2'd1;
    localparam logic [1:0] c_ALU_SLT = 2'd2;

    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam int c_NUM_REGS = 2 ** REG_ADDR_W;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]             w_opcode;
    logic [2:0]             w_funct3;
    logic [6:0]             w_funct7;
    logic [REG_ADDR_W-1:0]  w_rd_field;
    logic [WORD_LENGTH-1:0] w_imm_i;
    logic [WORD_LENGTH-1:0] w_imm_b;

    assign w_opcode   = if_inst[6:0];
    assign w_funct3   = if_inst[14:12];
    assign w_funct7   = if_inst[31:25];
    assign w_rd_field = if_inst[7 +: REG_ADDR_W];
    assign rs1_addr   = if_inst[15 +: REG_ADDR_W];
    assign rs2_addr   = if_inst[20 +: REG_ADDR_W];

    assign w_imm_i = {{(WORD_LENGTH-12){if_inst[31]}}, if_inst[31:20]};
    assign w_imm_b = {{(WORD_LENGTH-12){if_inst[31]}}, if_inst[7],
                      if_inst[30:25], if_inst[11:8], 1'b0};

    // ------------------------------------------------------------------
    // Decode classification
    // ------------------------------------------------------------------
    logic       w_dec_legal;
    logic [1:0] w_dec_fun;
    logic       w_dec_use_imm;
    logic       w_dec_branch;

    always_comb begin
        w_dec_legal   = 1'b0;
        w_dec_fun     = c_ALU_ADD;
        w_dec_use_imm = 1'b0;
        w_dec_branch  = 1'b0;
        case (w_opcode)
            c_OP_REG: begin
                if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000) begin
                    w_dec_legal = 1'b1;
                    w_dec_fun   = c_ALU_ADD;
                end else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) begin
                    w_dec_legal = 1'b1;
                    w_dec_fun   = c_ALU_SUB;
                end else if (w_funct3 == 3'b010 && w_funct7 == 7'b0000000) begin
                    w_dec_legal = 1'b1;
                    w_dec_fun   = c_ALU_SLT;
                end
            end
            c_OP_IMM: begin
                case (w_funct3)
                    3'b000: begin
                        w_dec_legal   = 1'b1;
                        w_dec_fun     = c_ALU_ADD;
                        w_dec_use_imm = 1'b1;
                    end
                    3'b010: begin
                        w_dec_legal   = 1'b1;
                        w_dec_fun     = c_ALU_SLT;
                        w_dec_use_imm = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_OP_BRANCH: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001) begin
                    w_dec_legal  = 1'b1;
                    w_dec_fun    = c_ALU_SUB;
                    w_dec_branch = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Illegal encodings collapse to ALU_ADD with zero operands so execute
    // sees a harmless no-op alongside the ex_illegal flag.
    logic [WORD_LENGTH-1:0] w_dec_data1;
    logic [WORD_LENGTH-1:0] w_dec_data2;
    logic [REG_ADDR_W-1:0]  w_dec_rd;
    logic                   w_dec_wb_en;
    logic                   w_dec_br_on_eq;
    logic [WORD_LENGTH-1:0] w_dec_br_target;

    assign w_dec_data1     = w_dec_legal ? rs1_data : '0;
    assign w_dec_data2     = !w_dec_legal  ? '0 :
                             w_dec_use_imm ? w_imm_i : rs2_data;
    assign w_dec_rd        = (w_dec_legal && !w_dec_branch) ? w_rd_field : '0;
    // Writes to x0 are architecturally discarded; dropping wb_en here also
    // keeps x0 out of the scoreboard.
    assign w_dec_wb_en     = w_dec_legal && !w_dec_branch && (w_rd_field != '0);
    assign w_dec_br_on_eq  = w_dec_legal && w_dec_branch && (w_funct3 == 3'b000);
    assign w_dec_br_target = (w_dec_legal && w_dec_branch) ? (if_pc + w_imm_b) : '0;

    // ------------------------------------------------------------------
    // Output slot registers
    // ------------------------------------------------------------------
    logic                   r_ex_valid;
    logic [1:0]             r_exec_fun;
    logic [WORD_LENGTH-1:0] r_data1;
    logic [WORD_LENGTH-1:0] r_data2;
    logic [REG_ADDR_W-1:0]  r_ex_rd;
    logic                   r_ex_wb_en;
    logic                   r_ex_is_branch;
    logic                   r_ex_br_on_eq;
    logic [WORD_LENGTH-1:0] r_ex_br_target;
    logic                   r_ex_illegal;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_consume;
    logic w_accept;
    logic w_if_ready;

    assign w_consume  = r_ex_valid && ex_ready;
    // Gated by rst so fetch never sees a ready while the block is held.
    assign w_if_ready = !rst && !flush && !w_stall && (!r_ex_valid || ex_ready);
    assign w_accept   = if_valid && w_if_ready;
    assign if_ready   = w_if_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_exec_fun     <= c_ALU_ADD;
            r_data1        <= '0;
            r_data2        <= '0;
            r_ex_rd        <= '0;
            r_ex_wb_en     <= 1'b0;
            r_ex_is_branch <= 1'b0;
            r_ex_br_on_eq  <= 1'b0;
            r_ex_br_target <= '0;
            r_ex_illegal   <= 1'b0;
        end else if (flush) begin
            // Flush beats a same-cycle consume: the slot is dropped unissued.
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid     <= 1'b1;
            r_exec_fun     <= w_dec_fun;
            r_data1        <= w_dec_data1;
            r_data2        <= w_dec_data2;
            r_ex_rd        <= w_dec_rd;
            r_ex_wb_en     <= w_dec_wb_en;
            r_ex_is_branch <= w_dec_branch;
            r_ex_br_on_eq  <= w_dec_br_on_eq;
            r_ex_br_target <= w_dec_br_target;
            r_ex_illegal   <= !w_dec_legal;
        end else if (w_consume) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign exec_fun     = r_exec_fun;
    assign data1        = r_data1;
    assign data2        = r_data2;
    assign ex_rd        = r_ex_rd;
    assign ex_wb_en     = r_ex_wb_en;
    assign ex_is_branch = r_ex_is_branch;
    assign ex_br_on_eq  = r_ex_br_on_eq;
    assign ex_br_target = r_ex_br_target;
    assign ex_illegal   = r_ex_illegal;

    // ------------------------------------------------------------------
    // Scoreboard / interlock
    // ------------------------------------------------------------------
`ifdef RISCV_ID_SCOREBOARD_EN
    logic [c_NUM_REGS-1:0] r_busy;
    logic [c_NUM_REGS-1:0] w_busy_nxt;
    logic                  w_uses_rs2;
    logic                  w_rs1_hazard;
    logic                  w_rs2_hazard;

    // Only register-register ALU ops and branches read rs2.
    assign w_uses_rs2 = (w_opcode == c_OP_REG) || (w_opcode == c_OP_BRANCH);

    // A source is blocked by a busy bit or by the producer still sitting in
    // the output slot (its busy bit is not set until it is consumed). The
    // busy bits are the registered copy, so a wb_valid clear only releases
    // the stall from the following cycle.
    assign w_rs1_hazard = (rs1_addr != '0) &&
                          (r_busy[rs1_addr] ||
                           (r_ex_valid && r_ex_wb_en && (r_ex_rd == rs1_addr)));
    assign w_rs2_hazard = (rs2_addr != '0) &&
                          (r_busy[rs2_addr] ||
                           (r_ex_valid && r_ex_wb_en && (r_ex_rd == rs2_addr)));
    assign w_stall      = w_rs1_hazard || (w_uses_rs2 && w_rs2_hazard);

    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        // Applied after the clear so a same-index set wins.
        if (w_consume && r_ex_wb_en && !flush) begin
            w_busy_nxt[r_ex_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end
`else
    logic w_unused_wb;

    assign w_stall     = 1'b0;
    assign w_unused_wb = &{1'b0, wb_valid, wb_rd};
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_id_stage
//  Description : Self-checking bench for riscv_id_stage. Directed scenarios
//                followed by randomized traffic, all compared against an
//                instruction-level reference model of the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_id_stage;

    localparam int W = 32;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_SLT = 2'd2;

`ifdef RISCV_ID_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         if_valid;
    logic         if_ready;
    logic [31:0]  if_inst;
    logic [W-1:0] if_pc;
    logic [4:0]   rs1_addr;
    logic [4:0]   rs2_addr;
    logic [W-1:0] rs1_data;
    logic [W-1:0] rs2_data;
    logic         ex_valid;
    logic         ex_ready;
    logic [1:0]   exec_fun;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic [4:0]   ex_rd;
    logic         ex_wb_en;
    logic         ex_is_branch;
    logic         ex_br_on_eq;
    logic [W-1:0] ex_br_target;
    logic         ex_illegal;
    logic         flush;
    logic         wb_valid;
    logic [4:0]   wb_rd;

    riscv_id_stage #(.WORD_LENGTH(W), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .exec_fun(exec_fun),
        .data1(data1), .data2(data2), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
        .ex_is_branch(ex_is_branch), .ex_br_on_eq(ex_br_on_eq),
        .ex_br_target(ex_br_target), .ex_illegal(ex_illegal),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction encoders
    // ------------------------------------------------------------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: what execute should see for one instruction
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]  fun;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        wb;
        logic        br;
        logic        eq;
        logic [31:0] tgt;
        logic        ill;
    } slot_t;

    function automatic slot_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
        slot_t s;
        int    kind;            // 0 illegal, 1 reg-reg ALU, 2 reg-imm ALU, 3 branch
        logic [1:0] fun;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic signed [11:0] imm12;
        logic signed [12:0] imm13;
        int immi;
        int immb;
        op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
        imm12 = inst[31:20];
        imm13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        immi  = imm12;
        immb  = imm13;
        kind  = 0;
        fun   = ALU_ADD;
        if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000)      begin kind = 1; fun = ALU_ADD; end
        else if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) begin kind = 1; fun = ALU_SUB; end
        else if (op == 7'b0110011 && f3 == 3'b010 && f7 == 7'b0000000) begin kind = 1; fun = ALU_SLT; end
        else if (op == 7'b0010011 && f3 == 3'b000)                     begin kind = 2; fun = ALU_ADD; end
        else if (op == 7'b0010011 && f3 == 3'b010)                     begin kind = 2; fun = ALU_SLT; end
        else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001))   begin kind = 3; fun = ALU_SUB; end
        s     = '0;
        s.fun = fun;
        s.ill = (kind == 0);
        if (kind == 1 || kind == 2) begin
            s.d1 = a;
            s.d2 = (kind == 1) ? b : 32'(immi);
            s.rd = inst[11:7];
            s.wb = (inst[11:7] != 5'd0);
        end
        if (kind == 3) begin
            s.d1  = a;
            s.d2  = b;
            s.br  = 1'b1;
            s.eq  = (f3 == 3'b000);
            s.tgt = pc + 32'(immb);
        end
        return s;
    endfunction

    logic  m_valid;
    slot_t m_slot;
    bit    m_busy [32];

    // Register r cannot be read yet: an older producer has not written back.
    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return m_busy[r] || (m_valid && m_slot.wb && m_slot.rd == r);
    endfunction

    function automatic logic [4:0] pick_busy();
        int start = $urandom_range(0, 31);
        for (int i = 0; i < 32; i++) begin
            if (m_busy[(start + i) % 32]) return 5'((start + i) % 32);
        end
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_slot  = '0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic rdy,
                         input logic fl, input logic wv, input logic [4:0] wr);
        if_valid = v;  if_inst = inst; if_pc = pc; rs1_data = a; rs2_data = b;
        ex_ready = rdy; flush = fl; wb_valid = wv; wb_rd = wr;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model.
    // Entered and left at posedge+1.
    task automatic step();
        slot_t dec;
        logic  exp_rdy, acc, con, uses2, stall, fl, wv;
        logic [4:0] r1, r2, wr;
        @(negedge clk);
        r1    = if_inst[19:15];
        r2    = if_inst[24:20];
        uses2 = (if_inst[6:0] == 7'b0110011) || (if_inst[6:0] == 7'b1100011);
        stall = SB_EN && (pending(r1) || (uses2 && pending(r2)));
        exp_rdy = !flush && !stall && (!m_valid || ex_ready);
        check_val("if_ready", 64'(if_ready), 64'(exp_rdy));
        check_val("rs1_addr", 64'(rs1_addr), 64'(r1));
        check_val("rs2_addr", 64'(rs2_addr), 64'(r2));
        check_val("ex_valid", 64'(ex_valid), 64'(m_valid));
        if (m_valid) begin
            check_val("exec_fun",     64'(exec_fun),     64'(m_slot.fun));
            check_val("data1",        64'(data1),        64'(m_slot.d1));
            check_val("data2",        64'(data2),        64'(m_slot.d2));
            check_val("ex_rd",        64'(ex_rd),        64'(m_slot.rd));
            check_val("ex_wb_en",     64'(ex_wb_en),     64'(m_slot.wb));
            check_val("ex_is_branch", 64'(ex_is_branch), 64'(m_slot.br));
            check_val("ex_br_on_eq",  64'(ex_br_on_eq),  64'(m_slot.eq));
            check_val("ex_br_target", 64'(ex_br_target), 64'(m_slot.tgt));
            check_val("ex_illegal",   64'(ex_illegal),   64'(m_slot.ill));
        end
        acc = if_valid && exp_rdy;
        con = m_valid && ex_ready;
        fl  = flush; wv = wb_valid; wr = wb_rd;
        dec = ref_decode(if_inst, if_pc, rs1_data, rs2_data);
        @(posedge clk);
        #1;
        if (SB_EN) begin
            if (wv) m_busy[wr] = 1'b0;
            if (con && m_slot.wb && !fl) m_busy[m_slot.rd] = 1'b1;
        end
        if (fl)       m_valid = 1'b0;
        else if (acc) begin m_valid = 1'b1; m_slot = dec; end
        else if (con) m_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ex_valid"}, 64'(ex_valid),     64'(0));
        check_val({tag, "_if_ready"}, 64'(if_ready),     64'(0));
        check_val({tag, "_fun"},      64'(exec_fun),     64'(ALU_ADD));
        check_val({tag, "_data1"},    64'(data1),        64'(0));
        check_val({tag, "_data2"},    64'(data2),        64'(0));
        check_val({tag, "_rd"},       64'(ex_rd),        64'(0));
        check_val({tag, "_wb"},       64'(ex_wb_en),     64'(0));
        check_val({tag, "_br"},       64'(ex_is_branch), 64'(0));
        check_val({tag, "_eq"},       64'(ex_br_on_eq),  64'(0));
        check_val({tag, "_tgt"},      64'(ex_br_target), 64'(0));
        check_val({tag, "_ill"},      64'(ex_illegal),   64'(0));
    endtask

    // Reset asserted between edges; outputs must drop without waiting for clk.
    task automatic async_reset();
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, s1, s2;
        logic [11:0] imm;
        logic [12:0] bimm;
        rd   = 5'($urandom_range(0, 7));
        s1   = 5'($urandom_range(0, 7));
        s2   = 5'($urandom_range(0, 7));
        imm  = 12'($urandom);
        bimm = {12'($urandom), 1'b0};
        case ($urandom_range(0, 9))
            0: return enc_r(7'h00, s2, s1, 3'b000, rd);
            1: return enc_r(7'h20, s2, s1, 3'b000, rd);
            2: return enc_r(7'h00, s2, s1, 3'b010, rd);
            3: return enc_i(imm, s1, 3'b000, rd);
            4: return enc_i(imm, s1, 3'b010, rd);
            5: return enc_b(bimm, s2, s1, 3'b000);
            6: return enc_b(bimm, s2, s1, 3'b001);
            7: return enc_r(7'h20, s2, s1, 3'($urandom_range(1, 7)), rd);
            8: return {imm, s1, 3'b010, rd, 7'b0000011};
            default: return $urandom;
        endcase
    endfunction

    logic [1:0]  hold_fun;
    logic [31:0] hold_d1, hold_d2;
    logic [4:0]  hold_rd;

    initial begin
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD x3,x1,x2
        drive(1, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7, 1, 0, 0, 5'd0);
        step();
        check_val("add_valid", 64'(ex_valid), 64'(1));
        check_val("add_fun",   64'(exec_fun), 64'(ALU_ADD));
        check_val("add_data1", 64'(data1),    64'(5));
        check_val("add_data2", 64'(data2),    64'(7));
        check_val("add_rd",    64'(ex_rd),    64'(3));
        check_val("add_wb",    64'(ex_wb_en), 64'(1));

        // ADDI x4,x0,-1
        drive(1, enc_i(12'hFFF, 5'd0, 3'b000, 5'd4), 32'h4, 32'd0, 32'd9, 1, 0, 0, 5'd0);
        step();
        check_val("addi_data2", 64'(data2),    64'(32'hFFFF_FFFF));
        check_val("addi_fun",   64'(exec_fun), 64'(ALU_ADD));

        // ADDI x0,x0,1
        drive(1, enc_i(12'd1, 5'd0, 3'b000, 5'd0), 32'h8, 32'd0, 32'd0, 1, 0, 0, 5'd0);
        step();
        check_val("addi_x0_wb", 64'(ex_wb_en), 64'(0));

        // BNE x1,x2,-8 at 0x100
        drive(1, enc_b(13'h1FF8, 5'd2, 5'd1, 3'b001), 32'h100, 32'd11, 32'd12, 1, 0, 0, 5'd0);
        step();
        check_val("bne_fun", 64'(exec_fun),     64'(ALU_SUB));
        check_val("bne_br",  64'(ex_is_branch), 64'(1));
        check_val("bne_eq",  64'(ex_br_on_eq),  64'(0));
        check_val("bne_tgt", 64'(ex_br_target), 64'(32'h0F8));

        // Flush while the next instruction is offered
        drive(1, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd7), 32'h104, 32'd1, 32'd2, 1, 1, 0, 5'd0);
        #1;
        check_val("flush_if_ready", 64'(if_ready), 64'(0));
        step();
        check_val("flush_ex_valid", 64'(ex_valid), 64'(0));

        // Retire x3 and x4, then build a dependency on x5
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1, 5'd3); step();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1, 5'd4); step();
        drive(1, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd5), 32'h200, 32'd3, 32'd4, 1, 0, 0, 5'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1, enc_r(7'h20, 5'd1, 5'd5, 3'b000, 5'd6), 32'h204, 32'd20, 32'd3, 1, 0, 0, 5'd0);
            step();
        end
        drive(1, enc_r(7'h20, 5'd1, 5'd5, 3'b000, 5'd6), 32'h204, 32'd20, 32'd3, 1, 0, 1, 5'd5);
        #1;
        check_val("sb_hold_on_wb", 64'(if_ready), 64'(!SB_EN));
        step();
        drive(1, enc_r(7'h20, 5'd1, 5'd5, 3'b000, 5'd6), 32'h204, 32'd20, 32'd3, 1, 0, 0, 5'd0);
        #1;
        check_val("sb_release", 64'(if_ready), 64'(1));
        step();
        check_val("sub_fun", 64'(exec_fun), 64'(ALU_SUB));
        check_val("sub_d1",  64'(data1),    64'(20));

        // Execute back-pressure: slot holds, fetch blocked
        hold_fun = exec_fun; hold_d1 = data1; hold_d2 = data2; hold_rd = ex_rd;
        for (int i = 0; i < 3; i++) begin
            drive(1, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd9), 32'h208, $urandom, $urandom, 0, 0, 0, 5'd0);
            #1;
            check_val("bp_if_ready", 64'(if_ready), 64'(0));
            step();
            check_val("bp_valid", 64'(ex_valid), 64'(1));
            check_val("bp_fun",   64'(exec_fun), 64'(hold_fun));
            check_val("bp_d1",    64'(data1),    64'(hold_d1));
            check_val("bp_d2",    64'(data2),    64'(hold_d2));
            check_val("bp_rd",    64'(ex_rd),    64'(hold_rd));
        end

        // Unsupported opcode (load)
        drive(1, {12'h0, 5'd0, 3'b010, 5'd10, 7'b0000011}, 32'h20C, 32'd0, 32'd0, 1, 0, 0, 5'd0);
        step();
        check_val("illegal_flag", 64'(ex_illegal), 64'(1));
        check_val("illegal_wb",   64'(ex_wb_en),   64'(0));

        // Reset while an x6 consumer waits behind a held slot
        drive(1, enc_r(7'h00, 5'd1, 5'd6, 3'b000, 5'd8), 32'h210, 32'd1, 32'd2, 0, 0, 0, 5'd0);
        step();
        async_reset();
        drive(1, enc_r(7'h00, 5'd1, 5'd6, 3'b000, 5'd8), 32'h210, 32'd1, 32'd2, 1, 0, 0, 5'd0);
        #1;
        check_val("post_rst_ready", 64'(if_ready), 64'(1));
        step();
        check_val("post_rst_valid", 64'(ex_valid), 64'(1));
        check_val("post_rst_rd",    64'(ex_rd),    64'(8));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            drive($urandom_range(0, 4) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
                  $urandom, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0, pick_busy());
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
